// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RISC-V core: controller states,
// datapath mux encodings and the ALU opcode constants used by the decoder.
package cpu_pkg;

   // Controller state encoding; the values also appear on the debug port.
   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      WB      = 3'd4,
      ERROR   = 3'd5
   } ctrl_state_t;

   // Next-PC mux select.
   localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;  // PC + 4
   localparam logic [1:0] PC_SRC_IMM   = 2'd1;  // PC + imm (branch / JAL)
   localparam logic [1:0] PC_SRC_JALR  = 2'd2;  // ALU result, bit 0 cleared

   // Register-file writeback mux select.
   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   // ALU opcodes shared with the instruction decoder.
   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;  // LUI

   // Width of the memory wait timer.
   localparam int TIMER_W = 16;

   // Writeback source: loads take memory data, jumps link PC+4, else ALU.
   function automatic logic [1:0] wb_sel_for(input logic mem_to_reg, input logic jump);
      if (mem_to_reg)
         return WB_SEL_MEM;
      else if (jump)
         return WB_SEL_PC4;
      else
         return WB_SEL_ALU;
   endfunction

   // Next-PC source at writeback: JALR uses the ALU target, JAL the immediate.
   function automatic logic [1:0] wb_pc_src_for(input logic jump, input logic jalr);
      if (!jump)
         return PC_SRC_PLUS4;
      else if (jalr)
         return PC_SRC_JALR;
      else
         return PC_SRC_IMM;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Bounded wait timer for the imem/dmem handshakes. Counts consecutive
// not-ready cycles and flags expiry once the count reaches MEM_TIMEOUT.
module multicycle_ctrl_mem_wait_timer
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   logic [TIMER_W-1:0] count;

   // Wait counter: cleared on reset and on every controller state change.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

   assign expired = (count >= TIMER_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: steps the shared datapath through
// fetch, decode, execute, memory and writeback, with bounded memory waits
// and a retired-instruction counter. Outputs are decoded from the state
// register and same-cycle inputs, and are forced to zero while rst is high.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic        branch,
   input  logic        jump,
   input  logic        jalr,
   input  logic        branch_taken,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        ir_load,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        retire,
   output logic [31:0] instret,
   output logic        bus_err,
   output logic [2:0]  state
);

   ctrl_state_t state_q, next_state;
   logic [31:0] instret_q;
   logic        timer_expired, timer_inc, timer_clear;

   logic       imem_req_c, ir_load_c, dmem_req_c, dmem_we_c, rf_we_c;
   logic       pc_write_c, retire_c;
   logic [1:0] wb_sel_c, pc_src_c;

   // Next-state and output decode for the sequencing FSM.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      next_state = state_q;
      imem_req_c = 1'b0;
      ir_load_c  = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      rf_we_c    = 1'b0;
      wb_sel_c   = WB_SEL_ALU;
      pc_write_c = 1'b0;
      pc_src_c   = PC_SRC_PLUS4;
      retire_c   = 1'b0;

      case (state_q)
         FETCH: begin
            imem_req_c = 1'b1;
            if (imem_ready) begin
               ir_load_c  = 1'b1;
               next_state = DECODE;
            end else if (timer_expired) begin
               next_state = ERROR;
            end
         end
         DECODE: next_state = EXECUTE;
         EXECUTE: begin
            if (mem_read || mem_write) begin
               next_state = MEM;
            end else if (branch) begin
               pc_write_c = 1'b1;
               pc_src_c   = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
               retire_c   = 1'b1;
               next_state = FETCH;
            end else if (jump || reg_write) begin
               next_state = WB;
            end else begin
               // Unrecognised or no-op: just advance the PC.
               pc_write_c = 1'b1;
               retire_c   = 1'b1;
               next_state = FETCH;
            end
         end
         MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = mem_write;
            if (dmem_ready) begin
               if (mem_write) begin
                  pc_write_c = 1'b1;
                  retire_c   = 1'b1;
                  next_state = FETCH;
               end else begin
                  next_state = WB;
               end
            end else if (timer_expired) begin
               next_state = ERROR;
            end
         end
         WB: begin
            rf_we_c    = reg_write;
            wb_sel_c   = wb_sel_for(mem_to_reg, jump);
            pc_write_c = 1'b1;
            pc_src_c   = wb_pc_src_for(jump, jalr);
            retire_c   = 1'b1;
            next_state = FETCH;
         end
         ERROR:   next_state = ERROR;
         default: next_state = ERROR;
      endcase
   end

   // State register; the fault state is left only through reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments; the comb decode above uses blocking.
      if (rst)
         state_q <= FETCH;
      else
         state_q <= next_state;
   end

   // Retired-instruction counter, wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst)
         instret_q <= '0;
      else if (retire_c)
         instret_q <= instret_q + 32'd1;
   end

   assign timer_inc   = ((state_q == FETCH) && !imem_ready) ||
                        ((state_q == MEM)   && !dmem_ready);
   assign timer_clear = (next_state != state_q);

   multicycle_ctrl_mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clear),
      .inc    (timer_inc),
      .expired(timer_expired)
   );

   assign imem_req = !rst && imem_req_c;
   assign ir_load  = !rst && ir_load_c;
   assign dmem_req = !rst && dmem_req_c;
   assign dmem_we  = !rst && dmem_we_c;
   assign rf_we    = !rst && rf_we_c;
   assign wb_sel   = rst ? 2'd0 : wb_sel_c;
   assign pc_write = !rst && pc_write_c;
   assign pc_src   = rst ? 2'd0 : pc_src_c;
   assign retire   = !rst && retire_c;
   assign instret  = rst ? 32'd0 : instret_q;
   assign bus_err  = !rst && (state_q == ERROR);
   assign state    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Expected retire events are queued
// when an instruction is issued and compared by a monitor when retire fires.
module tb_multicycle_ctrl;

   logic        clk, rst;
   logic        reg_write, mem_read, mem_write, mem_to_reg, branch, jump, jalr, branch_taken;
   logic        imem_ready, dmem_ready;
   logic        imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_write, retire, bus_err;
   logic [1:0]  wb_sel, pc_src;
   logic [31:0] instret;
   logic [2:0]  state;

   int assertions = 0;
   int failures   = 0;

   typedef struct {
      logic [1:0] pc_src;
      logic [1:0] wb_sel;
      logic       rf_we;
      int         lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_instret = 0;
   int          lat_cnt = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jalr(jalr),
      .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .rf_we(rf_we), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
      .retire(retire), .instret(instret), .bus_err(bus_err), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Retire monitor: pops the scoreboard and tracks the instret model.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         model_instret = 0;
         lat_cnt       = 0;
      end else begin
         lat_cnt++;
         assertions++;
         if (instret !== model_instret) begin
            failures++;
            $display("FAIL instret: got %0d expected %0d", instret, model_instret);
         end
         assertions++;
         if (pc_write !== retire) begin
            failures++;
            $display("FAIL pc_write_vs_retire: pc_write=%b retire=%b", pc_write, retire);
         end
         if (retire) begin
            assertions++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_retire: got retire expected none");
            end else begin
               e = sb.pop_front();
               if ({pc_src, wb_sel, rf_we} !== {e.pc_src, e.wb_sel, e.rf_we}) begin
                  failures++;
                  $display("FAIL retire_ctrl: got pc_src=%0d wb_sel=%0d rf_we=%b expected pc_src=%0d wb_sel=%0d rf_we=%b",
                           pc_src, wb_sel, rf_we, e.pc_src, e.wb_sel, e.rf_we);
               end
               assertions++;
               if (lat_cnt != e.lat) begin
                  failures++;
                  $display("FAIL latency: got %0d expected %0d", lat_cnt, e.lat);
               end
            end
            lat_cnt = 0;
            model_instret++;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctrl(input logic rw, mr, mw, m2r, br, j, jr, bt);
      reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
      branch = br; jump = j; jalr = jr; branch_taken = bt;
   endtask

   // Memory model + instruction driver: readies follow the requested wait
   // counts; returns once the DUT retires (bounded).
   task automatic run_instr(input int iwait, input int dwait,
                            output int mem_cycles, output bit we_seen, output bit rf_seen);
      int ic = 0, dc = 0, budget = 0;
      bit done = 0;
      mem_cycles = 0; we_seen = 0; rf_seen = 0;
      while (!done) begin
         imem_ready = (ic >= iwait);
         dmem_ready = (dc >= dwait);
         @(negedge clk);
         if (imem_req) ic++;
         if (dmem_req) begin
            dc++;
            mem_cycles++;
            if (dmem_we) we_seen = 1;
         end
         if (rf_we) rf_seen = 1;
         if (retire) done = 1;
         budget++;
         if (!done && budget > 100) begin
            assertions++;
            failures++;
            $display("FAIL retire_timeout: got no retire expected retire within 100 cycles");
            done = 1;
         end
         cyc();
      end
   endtask

   task automatic test_reset();
      set_ctrl(1, 1, 1, 1, 1, 1, 1, 1);
      imem_ready = 1; dmem_ready = 1; rst = 1;
      cyc();
      @(negedge clk);
      assertions++;
      if ({imem_req, ir_load, dmem_req, dmem_we, rf_we, wb_sel, pc_write, pc_src,
           retire, instret, bus_err, state} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got imem_req=%b dmem_req=%b rf_we=%b retire=%b instret=%0d state=%0d expected all zero",
                  imem_req, dmem_req, rf_we, retire, instret, state);
      end
      cyc();
      rst = 0; imem_ready = 0;
      set_ctrl(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      assertions++;
      if ({imem_req, state, bus_err, instret} !== {1'b1, 3'd0, 1'b0, 32'd0}) begin
         failures++;
         $display("FAIL first_fetch: got imem_req=%b state=%0d bus_err=%b instret=%0d expected 1 0 0 0",
                  imem_req, state, bus_err, instret);
      end
      cyc(); rst = 1;
      cyc(); rst = 0;
   endtask

   task automatic test_alu();
      int mc; bit we, rfs;
      set_ctrl(1, 0, 0, 0, 0, 0, 0, 0);
      sb.push_back('{2'd0, 2'd0, 1'b1, 4});
      run_instr(0, 0, mc, we, rfs);
      assertions++;
      if (instret !== 32'd1) begin
         failures++;
         $display("FAIL add_instret: got %0d expected 1", instret);
      end
   endtask

   task automatic test_load_wait();
      int mc; bit we, rfs;
      set_ctrl(1, 1, 0, 1, 0, 0, 0, 0);
      sb.push_back('{2'd0, 2'd1, 1'b1, 8});
      run_instr(0, 3, mc, we, rfs);
      assertions++;
      if (mc != 4 || we !== 1'b0) begin
         failures++;
         $display("FAIL lw_mem_phase: got mem_cycles=%0d we_seen=%b expected 4 0", mc, we);
      end
   endtask

   task automatic test_branch();
      int mc; bit we, rfs;
      set_ctrl(0, 0, 0, 0, 1, 0, 0, 1);
      sb.push_back('{2'd1, 2'd0, 1'b0, 3});
      run_instr(0, 0, mc, we, rfs);
      assertions++;
      if (rfs !== 1'b0) begin
         failures++;
         $display("FAIL beq_rf_we: got %b expected 0", rfs);
      end
      set_ctrl(0, 0, 0, 0, 1, 0, 0, 0);
      sb.push_back('{2'd0, 2'd0, 1'b0, 3});
      run_instr(0, 0, mc, we, rfs);
      assertions++;
      if (rfs !== 1'b0) begin
         failures++;
         $display("FAIL bne_rf_we: got %b expected 0", rfs);
      end
   endtask

   task automatic test_jump();
      int mc; bit we, rfs;
      set_ctrl(1, 0, 0, 0, 0, 1, 1, 0);
      sb.push_back('{2'd2, 2'd2, 1'b1, 4});
      run_instr(0, 0, mc, we, rfs);
      set_ctrl(1, 0, 0, 0, 0, 1, 0, 0);
      sb.push_back('{2'd1, 2'd2, 1'b1, 4});
      run_instr(0, 0, mc, we, rfs);
   endtask

   task automatic test_store_and_nop();
      int mc; bit we, rfs;
      set_ctrl(0, 0, 1, 0, 0, 0, 0, 0);
      sb.push_back('{2'd0, 2'd0, 1'b0, 4});
      run_instr(0, 0, mc, we, rfs);
      assertions++;
      if (mc != 1 || we !== 1'b1) begin
         failures++;
         $display("FAIL sw_mem_phase: got mem_cycles=%0d we_seen=%b expected 1 1", mc, we);
      end
      // dmem_ready lands exactly when the timer reaches MEM_TIMEOUT: no fault.
      sb.push_back('{2'd0, 2'd0, 1'b0, 10});
      run_instr(2, 4, mc, we, rfs);
      assertions++;
      if (mc != 5 || bus_err !== 1'b0 || state !== 3'd0) begin
         failures++;
         $display("FAIL ready_at_timeout: got mem_cycles=%0d bus_err=%b state=%0d expected 5 0 0",
                  mc, bus_err, state);
      end
      set_ctrl(0, 0, 0, 0, 0, 0, 0, 0);
      sb.push_back('{2'd0, 2'd0, 1'b0, 3});
      run_instr(0, 0, mc, we, rfs);
   endtask

   task automatic test_back_to_back();
      int mc; bit we, rfs;
      for (int i = 0; i < 12; i++) begin
         int op, w, d;
         op = $urandom_range(0, 5);
         w  = $urandom_range(0, 3);
         d  = $urandom_range(0, 3);
         case (op)
            0: begin set_ctrl(1, 0, 0, 0, 0, 0, 0, 0); sb.push_back('{2'd0, 2'd0, 1'b1, 4 + w}); end
            1: begin set_ctrl(0, 0, 0, 0, 1, 0, 0, 1); sb.push_back('{2'd1, 2'd0, 1'b0, 3 + w}); end
            2: begin set_ctrl(0, 0, 0, 0, 1, 0, 0, 0); sb.push_back('{2'd0, 2'd0, 1'b0, 3 + w}); end
            3: begin set_ctrl(1, 0, 0, 0, 0, 1, 0, 0); sb.push_back('{2'd1, 2'd2, 1'b1, 4 + w}); end
            4: begin set_ctrl(1, 1, 0, 1, 0, 0, 0, 0); sb.push_back('{2'd0, 2'd1, 1'b1, 5 + w + d}); end
            default: begin set_ctrl(0, 0, 0, 0, 0, 1, 0, 0); sb.push_back('{2'd1, 2'd2, 1'b0, 4 + w}); end
         endcase
         run_instr(w, d, mc, we, rfs);
      end
   endtask

   task automatic test_timeout();
      int fc = 0, budget = 0;
      bit in_err = 0;
      set_ctrl(0, 0, 0, 0, 0, 0, 0, 0);
      imem_ready = 0;
      while (!in_err && budget < 20) begin
         @(negedge clk);
         if (state == 3'd5) in_err = 1;
         else if (state == 3'd0 && imem_req) fc++;
         budget++;
         if (!in_err) cyc();
      end
      assertions++;
      if (!in_err || fc != 5) begin
         failures++;
         $display("FAIL timeout_entry: got in_error=%b fetch_cycles=%0d expected 1 5", in_err, fc);
      end
      cyc();
      @(negedge clk);
      assertions++;
      if ({bus_err, imem_req, state} !== {1'b1, 1'b0, 3'd5}) begin
         failures++;
         $display("FAIL error_state: got bus_err=%b imem_req=%b state=%0d expected 1 0 5",
                  bus_err, imem_req, state);
      end
      cyc(); rst = 1;
      @(negedge clk);
      assertions++;
      if (bus_err !== 1'b0) begin
         failures++;
         $display("FAIL bus_err_in_rst: got %b expected 0", bus_err);
      end
      cyc(); rst = 0;
      @(negedge clk);
      assertions++;
      if ({state, bus_err, imem_req} !== {3'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL error_recovery: got state=%0d bus_err=%b imem_req=%b expected 0 0 1",
                  state, bus_err, imem_req);
      end
      cyc(); rst = 1;
      cyc(); rst = 0;
   endtask

   task automatic test_abort();
      int mc; bit we, rfs;
      set_ctrl(1, 0, 0, 0, 0, 0, 0, 0);
      sb.push_back('{2'd0, 2'd0, 1'b1, 4});
      run_instr(0, 0, mc, we, rfs);
      set_ctrl(0, 0, 1, 0, 0, 0, 0, 0);
      imem_ready = 1; dmem_ready = 0;
      cyc(); cyc(); cyc();
      @(negedge clk);
      assertions++;
      if ({state, dmem_req, dmem_we, instret} !== {3'd3, 1'b1, 1'b1, 32'd1}) begin
         failures++;
         $display("FAIL store_in_mem: got state=%0d dmem_req=%b dmem_we=%b instret=%0d expected 3 1 1 1",
                  state, dmem_req, dmem_we, instret);
      end
      cyc(); rst = 1;
      @(negedge clk);
      assertions++;
      if ({dmem_req, retire, pc_write, instret} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
         failures++;
         $display("FAIL abort_in_rst: got dmem_req=%b retire=%b pc_write=%b instret=%0d expected 0 0 0 0",
                  dmem_req, retire, pc_write, instret);
      end
      cyc(); rst = 0;
      set_ctrl(0, 0, 0, 0, 0, 0, 0, 0);
      imem_ready = 0;
      @(negedge clk);
      assertions++;
      if ({state, imem_req, instret} !== {3'd0, 1'b1, 32'd0}) begin
         failures++;
         $display("FAIL abort_recovery: got state=%0d imem_req=%b instret=%0d expected 0 1 0",
                  state, imem_req, instret);
      end
      assertions++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
   endtask

   initial begin
      rst = 1;
      imem_ready = 0; dmem_ready = 0;
      set_ctrl(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_alu();
      test_load_wait();
      test_branch();
      test_jump();
      test_store_and_nop();
      test_back_to_back();
      test_timeout();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
